// File: rtl/crc_pkg.sv
// Shared CRC-32 constants, frame status record and checker state encoding for the RX path.
package crc_pkg;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam int          RX_LEN_W    = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } fcs_state_e;

  typedef struct packed {
    logic                fcs_err;
    logic                runt;
    logic                oversize;
    logic                phy_err;
    logic                trunc;
    logic [RX_LEN_W-1:0] len;
  } rx_status_t;

  localparam rx_status_t STATUS_NONE = rx_status_t'({(5 + RX_LEN_W){1'b0}});

  // One CRC step: register shifts toward the MSB, the incoming data bit is folded in at bit 31.
  function automatic logic [31:0] crc_bit(input logic [31:0] crc, input logic din);
    logic [31:0] shifted;
    shifted = {crc[30:0], 1'b0};
    if (crc[31] ^ din) begin
      return shifted ^ CRC_POLY;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/calculate_new_crc.sv
// Combinational CRC-32 update over one DATA_W-bit word, data consumed LSB first.
module calculate_new_crc
  import crc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [31:0]       crc_old,
  input  logic [DATA_W-1:0] data,
  output logic [31:0]       crc_new
);

  // Fold each data bit into the running CRC, lowest bit first
  always_comb begin
    crc_new = crc_old;
    for (int i = 0; i < DATA_W; i++) begin
      crc_new = crc_bit(crc_new, data[i]);
    end
  end

endmodule

// File: rtl/rx_fcs_checker.sv
// RX FCS checker: CRC-32 over the whole frame, FCS stripped by a 4-byte delay line,
// one registered status pulse per closed frame.
module rx_fcs_checker
  import crc_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int LEN_W         = RX_LEN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  input  logic             sof_i,
  input  logic             eof_i,
  input  logic             err_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             status_valid_o,
  output logic             fcs_err_o,
  output logic             runt_o,
  output logic             oversize_o,
  output logic             phy_err_o,
  output logic             trunc_o,
  output logic [LEN_W-1:0] frame_len_o
);

  fcs_state_e       state_r, state_nxt_s;
  logic [31:0]      crc_r, crc_nxt_s, crc_old_s, crc_new_s;
  logic [LEN_W-1:0] len_r, len_nxt_s, len_inc_s;
  logic             phy_r, phy_nxt_s;
  logic [2:0]       fill_r, fill_nxt_s;
  logic [7:0]       dl_data_r [4];
  logic [3:0]       dl_sof_r;
  logic             push_s, push_sof_s;

  logic [7:0]       out_data_s, data_r;
  logic             out_valid_s, out_sof_s, out_eof_s;
  logic             valid_r, sof_r, eof_r;
  logic             stat_valid_s, stat_valid_r;
  rx_status_t       stat_s, status_r;

  function automatic rx_status_t make_status(input logic fcs_err, input logic trunc,
                                             input logic phy_err, input logic [LEN_W-1:0] len);
    rx_status_t st;
    st.fcs_err  = fcs_err;
    st.runt     = (len < LEN_W'(MIN_FRAME_LEN));
    st.oversize = (len > LEN_W'(MAX_FRAME_LEN));
    st.phy_err  = phy_err;
    st.trunc    = trunc;
    st.len      = RX_LEN_W'(len);
    return st;
  endfunction

  // A sof byte always restarts the CRC, regardless of what was in flight
  always_comb begin
    if (sof_i) begin
      crc_old_s = CRC_INIT;
    end else begin
      crc_old_s = crc_r;
    end
  end

  calculate_new_crc #(.DATA_W(8)) u_crc (
    .crc_old (crc_old_s),
    .data    (data_i),
    .crc_new (crc_new_s)
  );

  // Saturating byte count including the byte being accepted
  always_comb begin
    if (&len_r) begin
      len_inc_s = len_r;
    end else begin
      len_inc_s = len_r + LEN_W'(1);
    end
  end

  // Next-state, delay-line control and output decode
  always_comb begin
    state_nxt_s  = state_r;
    crc_nxt_s    = crc_r;
    len_nxt_s    = len_r;
    phy_nxt_s    = phy_r;
    fill_nxt_s   = fill_r;
    push_s       = 1'b0;
    push_sof_s   = 1'b0;
    out_valid_s  = 1'b0;
    out_data_s   = 8'h00;
    out_sof_s    = 1'b0;
    out_eof_s    = 1'b0;
    stat_valid_s = 1'b0;
    stat_s       = STATUS_NONE;
    if (valid_i && sof_i) begin
      // an open frame is cut short: close it as truncated, then start afresh
      if (state_r != IDLE) begin
        stat_valid_s = 1'b1;
        stat_s       = make_status(1'b1, 1'b1, phy_r, len_r);
      end else begin
        stat_valid_s = 1'b0;
      end
      crc_nxt_s  = crc_new_s;
      len_nxt_s  = LEN_W'(1);
      phy_nxt_s  = err_i;
      push_s     = 1'b1;
      push_sof_s = 1'b1;
      fill_nxt_s = 3'd1;
      if (eof_i && (state_r == IDLE)) begin
        stat_valid_s = 1'b1;
        stat_s       = make_status(crc_new_s != CRC_RESIDUE, 1'b0, err_i, LEN_W'(1));
        state_nxt_s  = IDLE;
        fill_nxt_s   = 3'd0;
      end else if (eof_i) begin
        state_nxt_s = IDLE;
        fill_nxt_s  = 3'd0;
      end else begin
        state_nxt_s = FILL;
      end
    end else if (valid_i) begin
      case (state_r)
        FILL, STREAM: begin
          crc_nxt_s = crc_new_s;
          len_nxt_s = len_inc_s;
          phy_nxt_s = phy_r | err_i;
          push_s    = 1'b1;
          if (state_r == STREAM) begin
            out_valid_s = 1'b1;
            out_data_s  = dl_data_r[3];
            out_sof_s   = dl_sof_r[3];
            out_eof_s   = eof_i;
          end else begin
            fill_nxt_s = fill_r + 3'd1;
          end
          if (eof_i) begin
            stat_valid_s = 1'b1;
            stat_s       = make_status(crc_new_s != CRC_RESIDUE, 1'b0, phy_r | err_i, len_inc_s);
            state_nxt_s  = IDLE;
            fill_nxt_s   = 3'd0;
          end else if ((state_r == STREAM) || (fill_r == 3'd3)) begin
            state_nxt_s = STREAM;
          end else begin
            state_nxt_s = FILL;
          end
        end
        IDLE: begin
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, CRC, counter, delay line and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      crc_r        <= CRC_INIT;
      len_r        <= {LEN_W{1'b0}};
      phy_r        <= 1'b0;
      fill_r       <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        dl_data_r[i] <= 8'h00;
      end
      dl_sof_r     <= 4'h0;
      data_r       <= 8'h00;
      valid_r      <= 1'b0;
      sof_r        <= 1'b0;
      eof_r        <= 1'b0;
      stat_valid_r <= 1'b0;
      status_r     <= STATUS_NONE;
    end else begin
      state_r      <= state_nxt_s;
      crc_r        <= crc_nxt_s;
      len_r        <= len_nxt_s;
      phy_r        <= phy_nxt_s;
      fill_r       <= fill_nxt_s;
      if (push_s) begin
        dl_data_r[3] <= dl_data_r[2];
        dl_data_r[2] <= dl_data_r[1];
        dl_data_r[1] <= dl_data_r[0];
        dl_data_r[0] <= data_i;
        dl_sof_r     <= {dl_sof_r[2:0], push_sof_s};
      end
      data_r       <= out_data_s;
      valid_r      <= out_valid_s;
      sof_r        <= out_sof_s;
      eof_r        <= out_eof_s;
      stat_valid_r <= stat_valid_s;
      status_r     <= stat_s;
    end
  end

  assign data_o         = data_r;
  assign valid_o        = valid_r;
  assign sof_o          = sof_r;
  assign eof_o          = eof_r;
  assign status_valid_o = stat_valid_r;
  assign fcs_err_o      = status_r.fcs_err;
  assign runt_o         = status_r.runt;
  assign oversize_o     = status_r.oversize;
  assign phy_err_o      = status_r.phy_err;
  assign trunc_o        = status_r.trunc;
  assign frame_len_o    = LEN_W'(status_r.len);

endmodule
